instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ==========================================================================
// Module  : instr_fetch
// Brief   : credit-limited instruction fetch with redirect flush and queue
// Revision: 1.0
// ==========================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned        c_cnt_w = $clog2(QDEPTH + 1);
  localparam int unsigned        c_ptr_w = $clog2(QDEPTH);
  localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(QDEPTH);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(QDEPTH - 1);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        exp_pc_q, exp_pc_d;
  logic [c_cnt_w-1:0] inflight_q, inflight_d;
  logic [c_cnt_w-1:0] drop_cnt_q, drop_cnt_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0]        mem_q [QDEPTH];
  logic [63:0]        mem_d [QDEPTH];

  logic               w_req_fire;
  logic               w_rsp_fire;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [c_cnt_w:0]   w_occupancy;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Credits cover both queued words and requests still in flight, so a
  // kept response always finds a free FIFO slot.
  assign w_occupancy    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = ~reset & (w_occupancy < c_depth);
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = ~reset & (count_q != '0);
  assign inst_data      = mem_q[rd_ptr_q][31:0];
  assign inst_pc        = mem_q[rd_ptr_q][63:32];

  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_rsp_fire = imem_rsp_valid;
  assign w_drop     = redirect_valid | (drop_cnt_q != '0);
  assign w_push     = w_rsp_fire & ~w_drop;
  assign w_pop      = inst_valid & inst_ready & ~redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    exp_pc_d   = exp_pc_q;
    inflight_d = inflight_q + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_fire);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (w_req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Everything still outstanding after this edge belongs to the old path.
    if (redirect_valid) begin
      drop_cnt_d = inflight_d;
    end else if (w_rsp_fire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - c_cnt_w'(1);
    end

    if (redirect_valid) begin
      exp_pc_d = redirect_pc;
    end else if (w_push) begin
      exp_pc_d = exp_pc_q + 32'd4;
    end

    if (w_push) begin
      mem_d[wr_ptr_q] = {exp_pc_q, imem_rsp_data};
    end

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      exp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      exp_pc_q   <= exp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_rsp_valid) begin
      assert (inflight_q != '0)
        else $error("instr_fetch: response with no request in flight");
    end
  end

endmodule
`default_nettype wire
